// File: rtl/grid_write_scheduler_pkg.sv
// Shared types and geometry for the grid write scheduler.
// Pattern evaluation lives here so the walker stays counter-only.
package grid_write_scheduler_pkg;

  localparam int GRID_ROWS = 30;
  localparam int GRID_COLS = 40;
  localparam int CELLS     = GRID_ROWS * GRID_COLS;
  localparam int ADDR_W    = 11;
  localparam int ROW_W     = 5;
  localparam int COL_W     = 6;

  typedef enum logic [1:0] {
    PAT_ZERO,
    PAT_ONE,
    PAT_CHECK,
    PAT_ICHECK
  } pat_e;

  typedef enum logic {
    S_IDLE,
    S_FILL
  } state_e;

  function automatic logic pat_bit(
    input pat_e             p,
    input logic [ROW_W-1:0] r,
    input logic [COL_W-1:0] c
  );
    logic v;
    unique case (p)
      PAT_ZERO:   v = 1'b0;
      PAT_ONE:    v = 1'b1;
      PAT_CHECK:  v = r[0] ^ c[0];
      PAT_ICHECK: v = ~(r[0] ^ c[0]);
      default:    v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/grid_write_scheduler_walker.sv
// Row-major cell walker for the fill engine.
// Counters advance on step and wrap to cell 0 after the last cell.
module grid_fill_walker
  import grid_write_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step_i,
  input  pat_e              pat_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              data_o,
  output logic              last_o
);

  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign last_o = (addr_q == ADDR_W'(CELLS - 1));
  assign addr_o = addr_q;
  assign data_o = pat_bit(pat_i, row_q, col_q);

  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    addr_d = addr_q;
    if (step_i) begin
      if (last_o) begin
        row_d  = '0;
        col_d  = '0;
        addr_d = '0;
      end else begin
        addr_d = addr_q + 1'b1;
        if (col_q == COL_W'(GRID_COLS - 1)) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/grid_write_scheduler.sv
// Write-port sequencer for the 30x40 video grid: fill engine
// with absolute priority over two round-robin requesters.
module grid_write_scheduler
  import grid_write_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fill_start,
  input  logic [1:0]        fill_pattern,
  output logic              fill_busy,
  output logic              fill_done,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ROW_W-1:0]  a_row,
  input  logic [COL_W-1:0]  a_col,
  input  logic              a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ROW_W-1:0]  b_row,
  input  logic [COL_W-1:0]  b_col,
  input  logic              b_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              err_oob
);

  state_e            state_q, state_d;
  pat_e              pat_q, pat_d;
  logic              prio_a_q, prio_a_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              oob_q, oob_d;

  logic              in_fill;
  logic              fill_go;
  logic              arb_en;
  logic              accept;
  logic              oob;
  logic [ROW_W-1:0]  sel_row;
  logic [COL_W-1:0]  sel_col;
  logic              sel_data;
  logic [ADDR_W-1:0] lin_addr;
  logic              walk_step;
  pat_e              walk_pat;
  logic [ADDR_W-1:0] walk_addr;
  logic              walk_data;
  logic              walk_last;

  assign in_fill = (state_q == S_FILL);
  assign fill_go = (state_q == S_IDLE) && fill_start;
  assign arb_en  = (state_q == S_IDLE) && !fill_start;

  // prio_a_q set means A wins a tie (B was served last).
  assign a_ready = arb_en && a_valid && (!b_valid || prio_a_q);
  assign b_ready = arb_en && b_valid && (!a_valid || !prio_a_q);
  assign accept  = a_ready || b_ready;

  assign sel_row  = a_ready ? a_row  : b_row;
  assign sel_col  = a_ready ? a_col  : b_col;
  assign sel_data = a_ready ? a_data : b_data;
  assign oob      = (sel_row >= ROW_W'(GRID_ROWS)) ||
                    (sel_col >= COL_W'(GRID_COLS));
  assign lin_addr = ADDR_W'(sel_row) * ADDR_W'(GRID_COLS)
                  + ADDR_W'(sel_col);

  assign walk_step = fill_go || in_fill;
  assign walk_pat  = in_fill ? pat_q : pat_e'(fill_pattern);

  grid_fill_walker u_walker (
    .clk    (clk),
    .rst_n  (reset_n),
    .step_i (walk_step),
    .pat_i  (walk_pat),
    .addr_o (walk_addr),
    .data_o (walk_data),
    .last_o (walk_last)
  );

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    prio_a_d  = prio_a_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    oob_d     = 1'b0;
    unique case (1'b1)
      in_fill: begin
        wr_en_d   = 1'b1;
        wr_addr_d = walk_addr;
        wr_data_d = walk_data;
        if (walk_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      fill_go: begin
        state_d   = S_FILL;
        pat_d     = pat_e'(fill_pattern);
        wr_en_d   = 1'b1;
        wr_addr_d = walk_addr;
        wr_data_d = walk_data;
        busy_d    = 1'b1;
      end
      accept: begin
        prio_a_d = b_ready;
        if (oob) begin
          oob_d = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = lin_addr;
          wr_data_d = sel_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pat_q     <= PAT_ZERO;
      prio_a_q  <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      oob_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      prio_a_q  <= prio_a_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      oob_q     <= oob_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign fill_busy = busy_q;
  assign fill_done = done_q;
  assign err_oob   = oob_q;

endmodule

// File: tb/tb_grid_write_scheduler.sv
// Scoreboard bench for grid_write_scheduler: stimulus pushes
// expected write-port events, a negedge monitor pops and compares.
module tb_grid_write_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fill_start;
  logic [1:0]  fill_pattern;
  logic        fill_busy, fill_done;
  logic        a_valid, a_ready, a_data;
  logic [4:0]  a_row;
  logic [5:0]  a_col;
  logic        b_valid, b_ready, b_data;
  logic [4:0]  b_row;
  logic [5:0]  b_col;
  logic        wr_en, wr_data, err_oob;
  logic [10:0] wr_addr;

  typedef struct {
    logic        en;
    logic        oob;
    logic        done;
    logic [10:0] addr;
    logic        d;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;
  bit   check_en = 1'b1;
  bit   pa = 1'b1;

  grid_write_scheduler dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fill_start   (fill_start),
    .fill_pattern (fill_pattern),
    .fill_busy    (fill_busy),
    .fill_done    (fill_done),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_row        (a_row),
    .a_col        (a_col),
    .a_data       (a_data),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_row        (b_row),
    .b_col        (b_col),
    .b_data       (b_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .err_oob      (err_oob)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic push_w(input int addr, input logic d);
    exp_t e;
    e.en = 1'b1; e.oob = 1'b0; e.done = 1'b0;
    e.addr = 11'(addr); e.d = d;
    q.push_back(e);
  endtask

  task automatic push_oob();
    exp_t e;
    e.en = 1'b0; e.oob = 1'b1; e.done = 1'b0;
    e.addr = '0; e.d = 1'b0;
    q.push_back(e);
  endtask

  task automatic push_fill(input int p);
    exp_t e;
    int r, c, par;
    for (int i = 0; i < 1200; i++) begin
      r = i / 40;
      c = i % 40;
      par = (r + c) % 2;
      e.en = 1'b1; e.oob = 1'b0;
      e.done = (i == 1199);
      e.addr = 11'(i);
      case (p)
        0: e.d = 1'b0;
        1: e.d = 1'b1;
        2: e.d = par[0];
        default: e.d = ~par[0];
      endcase
      q.push_back(e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int r, input int c, input logic d);
    a_row = 5'(r); a_col = 6'(c); a_data = d;
  endtask

  task automatic set_b(input int r, input int c, input logic d);
    b_row = 5'(r); b_col = 6'(c); b_data = d;
  endtask

  always @(negedge clk) if (reset_n && fill_done) done_cnt++;

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && check_en && (wr_en || err_oob || fill_done)) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out en=%0b oob=%0b done=%0b addr=%0d",
                 wr_en, err_oob, fill_done, wr_addr);
      end else begin
        e = q.pop_front();
        if (wr_en !== e.en || err_oob !== e.oob || fill_done !== e.done ||
            (e.en && (wr_addr !== e.addr || wr_data !== e.d))) begin
          bad++;
          $display("FAIL wport got en=%0b oob=%0b done=%0b addr=%0d d=%0b want en=%0b oob=%0b done=%0b addr=%0d d=%0b",
                   wr_en, err_oob, fill_done, wr_addr, wr_data,
                   e.en, e.oob, e.done, e.addr, e.d);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // Tie table: A and B payloads with hand-computed addresses.
  int ta_r[2] = '{0, 29};
  int ta_c[2] = '{0, 39};
  int ta_a[2] = '{0, 1199};
  int tb_r[2] = '{10, 3};
  int tb_c[2] = '{20, 0};
  int tb_a[2] = '{420, 120};

  initial begin
    int ia, ib, viol, snap;
    reset_n = 1'b0;
    fill_start = 1'b0; fill_pattern = 2'd0;
    a_valid = 1'b0; b_valid = 1'b0;
    set_a(0, 0, 1'b0); set_b(0, 0, 1'b0);
    repeat (2) cyc();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_busy", fill_busy, 0);
    chk("rst_done", fill_done, 0);
    chk("rst_oob", err_oob, 0);
    reset_n = 1'b1;
    cyc();

    set_a(2, 3, 1'b1); a_valid = 1'b1; #1;
    chk("a_single_ready", a_ready, 1);
    push_w(83, 1'b1); pa = 1'b0;
    cyc(); a_valid = 1'b0;

    set_b(1, 1, 1'b0); b_valid = 1'b1; #1;
    chk("b_single_ready", b_ready, 1);
    push_w(41, 1'b0); pa = 1'b1;
    cyc(); b_valid = 1'b0;

    ia = 0; ib = 0;
    for (int i = 0; i < 4; i++) begin
      set_a(ta_r[ia], ta_c[ia], 1'b1);
      set_b(tb_r[ib], tb_c[ib], 1'b1);
      a_valid = 1'b1; b_valid = 1'b1; #1;
      chk($sformatf("tie%0d_a_ready", i), a_ready, int'(pa));
      chk($sformatf("tie%0d_b_ready", i), b_ready, int'(!pa));
      if (pa) begin push_w(ta_a[ia], 1'b1); ia++; end
      else    begin push_w(tb_a[ib], 1'b1); ib++; end
      pa = !pa;
      cyc();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    cyc();

    set_b(5, 7, 1'b1); b_valid = 1'b1;
    fill_start = 1'b1; fill_pattern = 2'd2; #1;
    chk("fillgo_a_ready", a_ready, 0);
    chk("fillgo_b_ready", b_ready, 0);
    push_fill(2);
    cyc(); fill_start = 1'b0;
    viol = 0;
    for (int k = 0; k < 1199; k++) begin
      if (b_ready) viol++;
      if (k == 600) chk("fill_busy_mid", fill_busy, 1);
      cyc();
    end
    chk("b_ready_in_fill", viol, 0);
    chk("fill_busy_end", fill_busy, 0);
    chk("b_ready_after", b_ready, 1);
    push_w(207, 1'b1); pa = 1'b1;
    cyc(); b_valid = 1'b0;

    set_a(30, 0, 1'b1); a_valid = 1'b1; #1;
    chk("oob_a_ready", a_ready, 1);
    push_oob(); pa = 1'b0;
    cyc();
    set_a(1, 2, 1'b1); set_b(2, 1, 1'b0); b_valid = 1'b1; #1;
    chk("post_oob_b_ready", b_ready, 1);
    chk("post_oob_a_ready", a_ready, 0);
    push_w(81, 1'b0);
    cyc(); b_valid = 1'b0; #1;
    chk("post_oob_a_next", a_ready, 1);
    push_w(42, 1'b1);
    cyc(); a_valid = 1'b0;
    set_b(0, 40, 1'b1); b_valid = 1'b1; #1;
    chk("oob_col_b_ready", b_ready, 1);
    push_oob();
    cyc(); b_valid = 1'b0;

    fill_start = 1'b1; fill_pattern = 2'd3; #1;
    push_fill(3);
    cyc();
    for (int k = 0; k < 1199; k++) begin
      fill_start = (k == 499);
      fill_pattern = 2'd0;
      cyc();
    end
    fill_start = 1'b0;
    repeat (3) cyc();
    chk("queue_drained", q.size(), 0);
    chk("done_count", done_cnt, 2);

    check_en = 1'b0;
    snap = done_cnt;
    fill_start = 1'b1; fill_pattern = 2'd1;
    cyc(); fill_start = 1'b0;
    repeat (299) cyc();
    chk("pre_rst_busy", fill_busy, 1);
    chk("pre_rst_wr_en", wr_en, 1);
    #3 reset_n = 1'b0; #1;
    chk("arst_wr_en", wr_en, 0);
    chk("arst_addr", wr_addr, 0);
    chk("arst_data", wr_data, 0);
    chk("arst_busy", fill_busy, 0);
    chk("arst_done", fill_done, 0);
    chk("arst_oob", err_oob, 0);
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    check_en = 1'b1;
    chk("post_rst_busy", fill_busy, 0);
    set_a(4, 4, 1'b1); set_b(6, 6, 1'b0);
    a_valid = 1'b1; b_valid = 1'b1; #1;
    chk("post_rst_a_wins", a_ready, 1);
    chk("post_rst_b_waits", b_ready, 0);
    push_w(164, 1'b1);
    cyc(); a_valid = 1'b0; b_valid = 1'b0;
    repeat (3) cyc();
    chk("no_done_after_rst", done_cnt, snap);
    chk("final_queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
